// File: rtl/aquarium_pump_sequencer.sv
// Hot/cold aquarium pump sequencer: arbitrates two level requests onto one pump with a valve dead time.
// Latency: decisions made on a clk edge show up on the registered outputs at that same edge (one clk after sampling).
// Backpressure: none; requests are levels, a request ignored in DEAD/RUN/FAULT is simply re-evaluated from IDLE.
module aquarium_pump_sequencer #(
    parameter int TICK_DIV  = 50000000,
    parameter int MIN_ON    = 5,
    parameter int DEAD_TIME = 2,
    parameter int MAX_RUN   = 60
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req_hot,
    input  logic       req_cold,
    input  logic       water_ok,
    input  logic       fault_clr,
    output logic       valve_hot,
    output logic       valve_cold,
    output logic       pump_en,
    output logic       fault,
    output logic       busy,
    output logic [2:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(MAX_RUN + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEAD     = 3'd1,
        S_RUN_HOT  = 3'd2,
        S_RUN_COLD = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc;
    logic          tick;
    logic [TW-1:0] timer;
    logic          grant_hot;     // 1 = hot side granted, 0 = cold side
    logic          grant_hot_d;
    logic          last_hot;      // side that most recently entered RUN
    logic          last_hot_d;
    logic          granted_req;

    assign tick        = (presc == PW'(TICK_DIV - 1));
    assign granted_req = grant_hot ? req_hot : req_cold;
    assign state       = state_q;

    // Free-running prescaler, independent of the sequencer state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Per-state tick timer: cleared on any state change, saturates at MAX_RUN.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            timer <= '0;
        end else if (state_d != state_q) begin
            timer <= '0;
        end else if (tick && (timer < TW'(MAX_RUN))) begin
            timer <= timer + TW'(1);
        end
    end

    // Next-state, grant latch and fairness bookkeeping.
    always_comb begin
        state_d     = state_q;
        grant_hot_d = grant_hot;
        last_hot_d  = last_hot;
        case (state_q)
            S_IDLE: begin
                if (water_ok && (req_hot || req_cold)) begin
                    state_d = S_DEAD;
                    if (req_hot && !req_cold) begin
                        grant_hot_d = 1'b1;
                    end else if (!req_hot && req_cold) begin
                        grant_hot_d = 1'b0;
                    end else begin
                        grant_hot_d = !last_hot;   // tie: serve the side not served last
                    end
                end
            end
            S_DEAD: begin
                if (!water_ok || !granted_req) begin
                    state_d = S_IDLE;
                end else if (timer >= TW'(DEAD_TIME)) begin
                    state_d    = grant_hot ? S_RUN_HOT : S_RUN_COLD;
                    last_hot_d = grant_hot;
                end
            end
            S_RUN_HOT, S_RUN_COLD: begin
                // Interlock beats minimum-on time, which beats the over-run fault.
                if (!water_ok) begin
                    state_d = S_IDLE;
                end else if (!granted_req && (timer >= TW'(MIN_ON))) begin
                    state_d = S_IDLE;
                end else if (timer >= TW'(MAX_RUN)) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, grant and registered outputs decoded from the next state so they change together.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            grant_hot  <= 1'b0;
            last_hot   <= 1'b0;
            valve_hot  <= 1'b0;
            valve_cold <= 1'b0;
            pump_en    <= 1'b0;
            fault      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_hot  <= grant_hot_d;
            last_hot   <= last_hot_d;
            valve_hot  <= (state_d == S_RUN_HOT)  || ((state_d == S_DEAD) && grant_hot_d);
            valve_cold <= (state_d == S_RUN_COLD) || ((state_d == S_DEAD) && !grant_hot_d);
            pump_en    <= (state_d == S_RUN_HOT)  || (state_d == S_RUN_COLD);
            fault      <= (state_d == S_FAULT);
            busy       <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_aquarium_pump_sequencer.sv
// Bench for aquarium_pump_sequencer: directed scenarios then random traffic against a reference model.
// Latency: expected outputs are queued at each clk edge and compared on the following falling edge.
// Backpressure: none; the DUT presents outputs every cycle, so one expectation is consumed per cycle.
module tb_aquarium_pump_sequencer;

    localparam int TD   = 4;
    localparam int MON  = 3;
    localparam int DT   = 2;
    localparam int MAXR = 8;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       req_hot = 1'b0;
    logic       req_cold = 1'b0;
    logic       water_ok = 1'b0;
    logic       fault_clr = 1'b0;
    logic       valve_hot, valve_cold, pump_en, fault, busy;
    logic [2:0] state;

    int checks = 0;
    int passes = 0;

    logic [7:0] exp_q[$];

    // Reference model: mode uses the published state codes; timer derived from edge counts.
    int m_mode     = 0;
    int m_cyc      = 0;   // edges since reset release; prescaler phase
    int m_entry    = -1;  // edge index at which the current mode was entered
    bit m_want_hot = 0;
    bit m_last_hot = 0;

    aquarium_pump_sequencer #(
        .TICK_DIV (TD),
        .MIN_ON   (MON),
        .DEAD_TIME(DT),
        .MAX_RUN  (MAXR)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req_hot   (req_hot),
        .req_cold  (req_cold),
        .water_ok  (water_ok),
        .fault_clr (fault_clr),
        .valve_hot (valve_hot),
        .valve_cold(valve_cold),
        .pump_en   (pump_en),
        .fault     (fault),
        .busy      (busy),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] expv);
        checks++;
        if (got === expv) passes++;
        else $display("FAIL %s got=%b expected=%b at %0t", name, got, expv, $time);
    endtask

    // Ticks seen by a timer entered at edge e, as observed just before edge n, capped at MAXR.
    function automatic int elapsed_ticks(input int e, input int n);
        int t;
        t = (n / TD) - ((e + 1) / TD);
        return (t > MAXR) ? MAXR : t;
    endfunction

    function automatic logic [7:0] expected_outputs(input int mode, input bit want_hot);
        logic vh, vc;
        vh = (mode == 2) || (mode == 1 && want_hot);
        vc = (mode == 3) || (mode == 1 && !want_hot);
        return {3'(mode), vh, vc, (mode == 2 || mode == 3), (mode == 4), (mode != 0)};
    endfunction

    // An asynchronous reset invalidates whatever was queued for the current cycle.
    always @(negedge clr) exp_q.delete();

    // Model step on every rising edge using the inputs the DUT samples.
    always @(posedge clk) begin
        int  n, t, nm;
        bit  own;
        if (!clr) begin
            m_mode = 0; m_cyc = 0; m_entry = -1; m_want_hot = 0; m_last_hot = 0;
        end else begin
            n  = m_cyc;
            t  = elapsed_ticks(m_entry, n);
            nm = m_mode;
            if (m_mode == 0) begin
                if (water_ok && (req_hot || req_cold)) begin
                    nm = 1;
                    m_want_hot = (req_hot && req_cold) ? !m_last_hot : req_hot;
                end
            end else if (m_mode == 1) begin
                own = m_want_hot ? req_hot : req_cold;
                if (!water_ok || !own) nm = 0;
                else if (t >= DT) begin
                    nm = m_want_hot ? 2 : 3;
                    m_last_hot = m_want_hot;
                end
            end else if (m_mode == 2 || m_mode == 3) begin
                own = (m_mode == 2) ? req_hot : req_cold;
                if (!water_ok) nm = 0;
                else if (!own && t >= MON) nm = 0;
                else if (t >= MAXR) nm = 4;
            end else begin
                if (fault_clr) nm = 0;
            end
            if (nm != m_mode) m_entry = n;
            m_mode = nm;
            m_cyc  = n + 1;
        end
        exp_q.push_back(expected_outputs(m_mode, m_want_hot));
    end

    // Monitor: one expectation per cycle, compared away from the active edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", {state, valve_hot, valve_cold, pump_en, fault, busy}, e);
            check("valve_excl", {7'd0, valve_hot & valve_cold}, 8'd0);
        end
    end

    task automatic drive(input logic h, input logic c, input logic w, input logic f);
        @(posedge clk);
        #2;
        req_hot = h; req_cold = c; water_ok = w; fault_clr = f;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {5'd0, state}, {5'd0, s});
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 clr = 1'b0;
        #1 check("reset_async", {3'd0, valve_hot, valve_cold, pump_en, fault, busy}, 8'd0);
        @(posedge clk);
        #2 clr = 1'b1;
    endtask

    initial begin
        bit h, c, w;
        // Reset held across a few edges: monitor checks reset outputs.
        repeat (3) @(posedge clk);
        #2 clr = 1'b1;

        // Hot request: DEAD, RUN_HOT, drop early, pump holds until MIN_ON.
        drive(1, 0, 1, 0);
        wait_state(3'd1, 10, "hot_dead");
        wait_state(3'd2, 20, "hot_run");
        repeat (TD) @(posedge clk);
        drive(0, 0, 1, 0);
        wait_state(3'd0, 30, "hot_min_on_exit");

        // Tie from reset goes hot, then cold after hot drops.
        pulse_reset();
        drive(1, 1, 1, 0);
        wait_state(3'd2, 20, "tie_hot_first");
        repeat (4 * TD) @(posedge clk);
        drive(0, 1, 1, 0);
        wait_state(3'd3, 40, "tie_then_cold");

        // Water loss during RUN_COLD.
        repeat (TD + 1) @(posedge clk);
        drive(0, 1, 0, 0);
        repeat (3) @(posedge clk);
        drive(0, 0, 1, 0);

        // Over-run fault, ignored requests, clear.
        drive(0, 1, 1, 0);
        wait_state(3'd4, 80, "overrun_fault");
        drive(1, 1, 0, 0);
        repeat (6) @(posedge clk);
        drive(1, 1, 1, 1);
        drive(0, 0, 1, 0);
        wait_state(3'd0, 5, "fault_cleared");

        // Reset mid-RUN_HOT, then the tie goes hot again.
        drive(1, 0, 1, 0);
        wait_state(3'd2, 20, "pre_reset_run");
        @(posedge clk);
        #3 clr = 1'b0;
        #1 check("reset_mid_run", {3'd0, valve_hot, valve_cold, pump_en, fault, busy}, 8'd0);
        req_cold = 1'b1;
        @(posedge clk);
        #2 clr = 1'b1;
        wait_state(3'd1, 5, "post_reset_dead");
        check("post_reset_tie_hot", {7'd0, valve_hot}, 8'd1);

        // Random traffic against the model.
        h = 0; c = 0; w = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29, 0) == 0) h = !h;
            if ($urandom_range(29, 0) == 0) c = !c;
            if (w) begin
                if ($urandom_range(59, 0) == 0) w = 0;
            end else if ($urandom_range(7, 0) == 0) w = 1;
            drive(h, c, w, ($urandom_range(15, 0) == 0));
            if ($urandom_range(799, 0) == 0) pulse_reset();
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/aquarium_pump_sequencer.md
AQUARIUM_PUMP_SEQUENCER -- requirements
Module: aquarium_pump_sequencer

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 50000000, clocks per timing tick (1 s at 50 MHz).
REQ-002 SHALL provide parameter MIN_ON, default 5, minimum RUN duration in ticks.
REQ-003 SHALL provide parameter DEAD_TIME, default 2, valve-settle ticks before the pump starts.
REQ-004 SHALL provide parameter MAX_RUN, default 60, RUN ticks before a fault is declared.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk, input, 1, system clock, rising edge.
REQ-007 SHALL have port clr, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_hot, input, 1, hot-pump request, level.
REQ-009 SHALL have port req_cold, input, 1, cold-pump request, level.
REQ-010 SHALL have port water_ok, input, 1, water-level interlock; 1 = safe to pump.
REQ-011 SHALL have port fault_clr, input, 1, clears FAULT, sampled on clk.
REQ-012 SHALL have port valve_hot, output, 1, hot valve open.
REQ-013 SHALL have port valve_cold, output, 1, cold valve open.
REQ-014 SHALL have port pump_en, output, 1, shared pump motor enable.
REQ-015 SHALL have port fault, output, 1, over-run fault flag.
REQ-016 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-017 SHALL have port state, output, 3, IDLE=0, DEAD=1, RUN_HOT=2, RUN_COLD=3, FAULT=4.

Function
REQ-018 SHALL generate tick: prescaler counts 0..TICK_DIV-1, pulses tick for one clk when at TICK_DIV-1, then wraps to 0; free-running, unaffected by state.
REQ-019 SHALL keep a state timer that clears on every state entry, increments on tick, and saturates at MAX_RUN.
REQ-020 SHALL register all outputs; the transition to a new state appears on outputs one clk after the deciding edge.
REQ-021 IDLE: all outputs 0; when water_ok=1 and any request is high, latch a grant and go to DEAD.
REQ-022 Arbitration: single request wins; with both high, grant goes to the side not served last (last_served flag, updated on RUN entry).
REQ-023 DEAD: granted valve=1, pump_en=0; after DEAD_TIME ticks go to RUN_HOT or RUN_COLD per grant.
REQ-024 DEAD: if the granted request drops or water_ok=0, go to IDLE immediately, without completing dead time.
REQ-025 RUN_x: granted valve=1, pump_en=1, other valve=0 (both valves never 1 together in any state).
REQ-026 RUN_x: go to IDLE when the granted request is low and timer >= MIN_ON; the request is ignored before MIN_ON.
REQ-027 RUN_x: water_ok=0 forces IDLE on the next edge, overriding MIN_ON.
REQ-028 RUN_x: timer reaching MAX_RUN with request still high goes to FAULT; a simultaneous water_ok=0 takes priority (IDLE).
REQ-029 FAULT: valves 0, pump_en 0, fault=1; exit to IDLE only on fault_clr=1; requests and water_ok are ignored.
REQ-030 SHALL switch between hot and cold only via IDLE and DEAD, so a full DEAD_TIME separates opposite pumping.
REQ-031 SHALL ignore fault_clr outside FAULT.

Reset
REQ-032 clr=0 SHALL asynchronously force state=IDLE, all outputs 0, prescaler=0, timer=0, grant cleared, last_served=cold (hot wins the first tie).
REQ-033 Reset asserted mid-RUN SHALL drop pump_en and valves without waiting for a clock edge.

Verification (TICK_DIV=4, MIN_ON=3, DEAD_TIME=2, MAX_RUN=8)
REQ-034 req_hot=1, water_ok=1 held -> DEAD with valve_hot=1 for 2 ticks, then RUN_HOT with pump_en=1; drop req at tick 1 of RUN -> pump stays on until timer=3, then IDLE.
REQ-035 req_hot=req_cold=1 from reset -> hot served first; drop hot after MIN_ON -> IDLE, DEAD, RUN_COLD; valve_hot and valve_cold never both 1.
REQ-036 water_ok falls during RUN_COLD at timer=1 -> IDLE and all outputs 0 on the next edge.
REQ-037 req_cold held for 8 ticks in RUN -> FAULT, fault=1, pump_en=0; requests ignored; fault_clr pulse -> IDLE, fault=0.
REQ-038 clr pulsed low mid-RUN_HOT between clock edges -> outputs 0 immediately; after release, state=IDLE and the tie goes to hot.
